// File: rtl/div_bcd_pkg.sv
// Shared types and constants for the divider-result BCD converter.
// Holds the FSM state encoding, default widths and the double-dabble
// adjust constants used by div_bcd_conv and dd_digit_adj.
package div_bcd_pkg;

  localparam int unsigned DEF_W      = 8;  // binary input width
  localparam int unsigned DEF_DIGITS = 3;  // BCD digits per result
  localparam int unsigned NIB_W      = 4;  // width of one BCD digit

  // Digits at or above ADJ_THRESH get ADJ_ADD before each shift
  localparam logic [NIB_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [NIB_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV_Q = 3'd1,
    ST_LOAD_R = 3'd2,
    ST_CONV_R = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/dd_digit_adj.sv
// Single-nibble double-dabble adjust: adds ADJ_ADD when the digit is
// ADJ_THRESH or more, otherwise passes it through.
// Ports:
//   digit      in   NIB_W  current BCD digit
//   adjusted_c out  NIB_W  digit after add-3 adjust (combinational)
module dd_digit_adj
  import div_bcd_pkg::*;
(
  input  logic [NIB_W-1:0] digit,
  output logic [NIB_W-1:0] adjusted_c
);

  always_comb begin
    adjusted_c = digit;
    if (digit >= ADJ_THRESH) begin
      adjusted_c = digit + ADJ_ADD;
    end
  end

endmodule

// File: rtl/div_bcd_conv.sv
// Converts each divider result (Quotient, optionally Reminder) to packed
// BCD by sequential double-dabble, one bit per clock. A rising edge of
// done_sig starts a conversion; rises arriving while a conversion is in
// progress are dropped and flagged on the sticky overrun_sig.
// Optional feature macro: REM_BCD_EN (also converts Reminder into bcd_r).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   done_sig     divider done level; rising edge = new result
//   Quotient     divider quotient (W bits)
//   Reminder     divider remainder (W bits)
//   clr_sig      clears overrun_sig
//   bcd_q        packed BCD quotient, MS digit in top nibble
//   bcd_r        packed BCD remainder (0 unless REM_BCD_EN)
//   valid_sig    one-cycle pulse when bcd_q/bcd_r update
//   busy_sig     high while converting
//   overrun_sig  sticky flag: a done_sig rise was dropped
module div_bcd_conv
  import div_bcd_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    done_sig,
  input  logic [W-1:0]            Quotient,
  input  logic [W-1:0]            Reminder,
  input  logic                    clr_sig,
  output logic [NIB_W*DIGITS-1:0] bcd_q,
  output logic [NIB_W*DIGITS-1:0] bcd_r,
  output logic                    valid_sig,
  output logic                    busy_sig,
  output logic                    overrun_sig
);

  localparam int unsigned BCD_W = NIB_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  state_t           state;
  logic             done_d;
  logic [W-1:0]     shift;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj_c;
  logic [CNT_W-1:0] cnt;
  logic             rise_c;
  logic             in_conv_c;
  logic             accept_c;

`ifdef REM_BCD_EN
  logic [W-1:0]     rem_hold;
  logic [BCD_W-1:0] q_hold;
  logic [BCD_W-1:0] bcd_r_q;
  assign bcd_r = bcd_r_q;
`else
  logic unused_rem;
  assign unused_rem = ^Reminder;
  assign bcd_r      = '0;
`endif

  assign rise_c    = done_sig & ~done_d;
  assign in_conv_c = (state != ST_IDLE) && (state != ST_OUT);
  // New results are taken only when idle or presenting the previous one
  assign accept_c  = rise_c & ~in_conv_c;

  // Per-digit add-3 adjust of the accumulator ahead of each shift
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    dd_digit_adj u_adj (
      .digit      (acc[gi*NIB_W +: NIB_W]),
      .adjusted_c (acc_adj_c[gi*NIB_W +: NIB_W])
    );
  end

  // FSM, datapath, edge detect and overrun flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      done_d      <= 1'b1;  // a level held across reset is not a rise
      shift       <= '0;
      acc         <= '0;
      cnt         <= '0;
      bcd_q       <= '0;
      valid_sig   <= 1'b0;
      busy_sig    <= 1'b0;
      overrun_sig <= 1'b0;
`ifdef REM_BCD_EN
      rem_hold    <= '0;
      q_hold      <= '0;
      bcd_r_q     <= '0;
`endif
    end else begin
      done_d    <= done_sig;
      valid_sig <= 1'b0;

      // Set beats clear when both happen on the same edge
      if (rise_c && in_conv_c) begin
        overrun_sig <= 1'b1;
      end else if (clr_sig) begin
        overrun_sig <= 1'b0;
      end

      // Present the finished result; acc still holds it this cycle
      if (state == ST_OUT) begin
        valid_sig <= 1'b1;
`ifdef REM_BCD_EN
        bcd_q   <= q_hold;
        bcd_r_q <= acc;
`else
        bcd_q   <= acc;
`endif
      end

      if (accept_c) begin
        shift    <= Quotient;
        acc      <= '0;
        cnt      <= '0;
        state    <= ST_CONV_Q;
        busy_sig <= 1'b1;
`ifdef REM_BCD_EN
        rem_hold <= Reminder;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            busy_sig <= 1'b0;
          end
          ST_CONV_Q: begin
            {acc, shift} <= {acc_adj_c, shift} << 1;
            cnt          <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
              cnt <= '0;
`ifdef REM_BCD_EN
              state <= ST_LOAD_R;
`else
              state    <= ST_OUT;
              busy_sig <= 1'b0;
`endif
            end
          end
`ifdef REM_BCD_EN
          ST_LOAD_R: begin
            q_hold <= acc;
            shift  <= rem_hold;
            acc    <= '0;
            cnt    <= '0;
            state  <= ST_CONV_R;
          end
          ST_CONV_R: begin
            {acc, shift} <= {acc_adj_c, shift} << 1;
            cnt          <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
              cnt      <= '0;
              state    <= ST_OUT;
              busy_sig <= 1'b0;
            end
          end
`endif
          ST_OUT: begin
            state    <= ST_IDLE;
            busy_sig <= 1'b0;
          end
          default: begin
            state    <= ST_IDLE;
            busy_sig <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_bcd_conv.sv
// Self-checking bench for div_bcd_conv: a cycle-level behavioural model
// (accept/drop bookkeeping plus decimal arithmetic) checked every cycle,
// plus directed vectors with literal expected values.
module tb_div_bcd_conv;

`ifdef REM_BCD_EN
  localparam int LAT    = 18;
  localparam bit REM_EN = 1'b1;
`else
  localparam int LAT    = 9;
  localparam bit REM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done_sig;
  logic [7:0]  quotient;
  logic [7:0]  reminder;
  logic        clr_sig;
  logic [11:0] bcd_q;
  logic [11:0] bcd_r;
  logic        valid_sig;
  logic        busy_sig;
  logic        overrun_sig;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  div_bcd_conv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .done_sig    (done_sig),
    .Quotient    (quotient),
    .Reminder    (reminder),
    .clr_sig     (clr_sig),
    .bcd_q       (bcd_q),
    .bcd_r       (bcd_r),
    .valid_sig   (valid_sig),
    .busy_sig    (busy_sig),
    .overrun_sig (overrun_sig)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [11:0] rlit(input logic [11:0] v);
    return REM_EN ? v : 12'h000;
  endfunction

  // Behavioural model: counts edges to each accepted result's delivery
  logic        m_done_d, m_pend, m_valid, m_busy, m_ovr;
  int          m_left;
  logic [7:0]  m_lq, m_lr;
  logic [11:0] m_q, m_r;

  always @(posedge clk) begin : model
    int          left;
    bit          pend, rise, vld, ovr;
    logic [11:0] q, r;
    if (!rst_n) begin
      m_done_d <= 1'b1; m_pend <= 1'b0; m_left <= 0; m_valid <= 1'b0;
      m_busy <= 1'b0; m_ovr <= 1'b0; m_q <= '0; m_r <= '0; m_lq <= '0; m_lr <= '0;
    end else begin
      pend = m_pend; left = m_left; vld = 1'b0; q = m_q; r = m_r; ovr = m_ovr;
      if (pend) begin
        left = left - 1;
        if (left == 0) begin
          vld = 1'b1; q = to_bcd(int'(m_lq)); r = to_bcd(int'(m_lr)); pend = 1'b0;
        end
      end
      rise = done_sig && !m_done_d;
      if (rise && pend) ovr = 1'b1;
      else if (clr_sig) ovr = 1'b0;
      if (rise && !pend) begin
        pend = 1'b1; left = LAT; m_lq <= quotient; m_lr <= reminder;
      end
      m_done_d <= done_sig;
      m_pend   <= pend;
      m_left   <= left;
      m_valid  <= vld;
      m_busy   <= pend && (left > 1);
      m_ovr    <= ovr;
      m_q      <= q;
      m_r      <= r;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_sig", 32'(valid_sig), 32'(m_valid));
      check("busy_sig", 32'(busy_sig), 32'(m_busy));
      check("overrun_sig", 32'(overrun_sig), 32'(m_ovr));
      check("bcd_q", 32'(bcd_q), 32'(m_q));
      check("bcd_r", 32'(bcd_r), REM_EN ? 32'(m_r) : 32'd0);
    end
  end

  task automatic step(input logic r, input logic d, input logic [7:0] q,
                      input logic [7:0] rm, input logic c);
    rst_n = r; done_sig = d; quotient = q; reminder = rm; clr_sig = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  // One isolated conversion with literal expectations on latency and value
  task automatic convert(input logic [7:0] q, input logic [7:0] rm,
                         input logic [11:0] eq, input logic [11:0] er);
    step(1'b1, 1'b1, q, rm, 1'b0);
    idle(LAT - 1);
    check("valid_early", 32'(valid_sig), 32'd0);
    idle(1);
    check("valid_at_lat", 32'(valid_sig), 32'd1);
    check("bcd_q_lit", 32'(bcd_q), 32'(eq));
    check("bcd_r_lit", 32'(bcd_r), 32'(er));
    idle(1);
    check("valid_one_cycle", 32'(valid_sig), 32'd0);
    check("bcd_q_hold", 32'(bcd_q), 32'(eq));
  endtask

  logic [7:0]  tq[3] = '{8'd255, 8'd0,   8'd99};
  logic [7:0]  tr[3] = '{8'd9,   8'd200, 8'd17};
  logic [11:0] eq[3] = '{12'h255, 12'h000, 12'h099};
  logic [11:0] er[3] = '{12'h009, 12'h200, 12'h017};

  initial begin : stim
    int pulses;
    rst_n = 1'b0; done_sig = 1'b0; quotient = '0; reminder = '0; clr_sig = 1'b0;
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk_en = 1'b1;
    check("rst_bcd_q", 32'(bcd_q), 32'd0);
    check("rst_valid", 32'(valid_sig), 32'd0);
    check("rst_busy", 32'(busy_sig), 32'd0);
    check("rst_overrun", 32'(overrun_sig), 32'd0);
    idle(2);

    // 243/10 -> quotient 24, remainder 3
    convert(8'd24, 8'd3, 12'h024, rlit(12'h003));
    idle(2);

    // Boundary and mid-range values
    for (int i = 0; i < 3; i++) begin
      convert(tq[i], tr[i], eq[i], rlit(er[i]));
      idle(1);
    end

    // Level held for six cycles yields a single result and no overrun
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'd42, 8'd1, 1'b0);
      pulses += int'(valid_sig);
    end
    for (int i = 0; i < LAT + 10; i++) begin
      idle(1);
      pulses += int'(valid_sig);
    end
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_overrun", 32'(overrun_sig), 32'd0);
    check("held_bcd_q", 32'(bcd_q), 32'h042);

    // Second rise at E4 is dropped; first result still delivered
    step(1'b1, 1'b1, 8'd24, 8'd3, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 8'd7, 8'd5, 1'b0);
    check("drop_overrun", 32'(overrun_sig), 32'd1);
    idle(LAT - 5);
    check("drop_valid_early", 32'(valid_sig), 32'd0);
    idle(1);
    check("drop_valid", 32'(valid_sig), 32'd1);
    check("drop_bcd_q", 32'(bcd_q), 32'h024);
    idle(2);
    check("drop_no_retry", 32'(busy_sig), 32'd0);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    check("clr_overrun", 32'(overrun_sig), 32'd0);

    // Clear coincident with a drop: set wins
    step(1'b1, 1'b1, 8'd24, 8'd3, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 8'd7, 8'd5, 1'b1);
    check("clr_vs_set", 32'(overrun_sig), 32'd1);
    idle(LAT);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    idle(2);

    // Reset mid-conversion with done held high through release
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'd24, 8'd3, 1'b0);
    step(1'b0, 1'b1, 8'd24, 8'd3, 1'b0);
    check("midrst_bcd_q", 32'(bcd_q), 32'd0);
    check("midrst_busy", 32'(busy_sig), 32'd0);
    pulses = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      step(1'b1, 1'b1, 8'd24, 8'd3, 1'b0);
      pulses += int'(valid_sig);
    end
    check("midrst_no_valid", 32'(pulses), 32'd0);
    check("midrst_bcd_q_hold", 32'(bcd_q), 32'd0);
    idle(1);
    convert(8'd13, 8'd4, 12'h013, rlit(12'h004));
    idle(2);

    // Back-to-back: second rise on the OUT cycle is accepted
    step(1'b1, 1'b1, 8'd24, 8'd3, 1'b0);
    idle(LAT - 1);
    step(1'b1, 1'b1, 8'd13, 8'd4, 1'b0);
    check("b2b_valid1", 32'(valid_sig), 32'd1);
    check("b2b_bcd_q1", 32'(bcd_q), 32'h024);
    idle(LAT - 1);
    check("b2b_gap", 32'(valid_sig), 32'd0);
    idle(1);
    check("b2b_valid2", 32'(valid_sig), 32'd1);
    check("b2b_bcd_q2", 32'(bcd_q), 32'h013);
    check("b2b_bcd_r2", 32'(bcd_r), 32'(rlit(12'h004)));
    check("b2b_overrun", 32'(overrun_sig), 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
